power_seq: RTL and testbench
============================

POWER_SEQ -- requirements
Module: power_seq

Interface
REQ-001 Parameter DELAY, default 1000, wait cycles after each sequencer write (legal 1..65535).
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to run power-up sequence.
REQ-005 stop  input  1  one-cycle request to run power-down sequence.
REQ-006 host_data  input  8  host write data for the register block.
REQ-007 host_valid  input  10  host one-hot register select (bit i = register i); multi-hot is forwarded as given.
REQ-008 master_data  output  8  data to register block, registered.
REQ-009 valid_bus  output  10  register write strobes to register block, registered.
REQ-010 host_ready  output  1  high when host writes are being forwarded.
REQ-011 host_reject  output  1  one-cycle pulse when a host write is dropped.
REQ-012 busy  output  1  high while a power-up or power-down sequence is running.
REQ-013 power_good  output  1  high only in state ON.

Function
REQ-014 States: OFF, UP_WR, UP_WAIT, ON, DN_WR, DN_WAIT; 3-bit step index; 16-bit wait counter.
REQ-015 Register map driven: 6 functional (data[0]), 7 off_vcore (data[0]), 8 off_vdigital (data[0]), 9 {ena_clpdm, stby, rst} = data[2:0].
REQ-016 Power-up steps in order: s0 reg9=0x01, s1 reg7=0x00, s2 reg8=0x00, s3 reg6=0x01, s4 reg9=0x00.
REQ-017 Power-down steps in order: d0 reg9=0x01, d1 reg6=0x00, d2 reg8=0x01, d3 reg7=0x01.
REQ-018 *_WR state: drive valid_bus one-hot for the step register and master_data for one cycle, then go to *_WAIT with counter loaded to DELAY.
REQ-019 *_WAIT: decrement each cycle; at counter 1 go to next step's *_WR, or after last step to ON (up) / OFF (down).
REQ-020 Consecutive sequencer writes SHALL be exactly DELAY+1 cycles apart; valid_bus SHALL be zero in all other sequencing cycles.
REQ-021 OFF: start moves to UP_WR s0 next cycle; stop ignored.
REQ-022 ON: stop moves to DN_WR d0 next cycle; start ignored.
REQ-023 start and stop in the same cycle: stop wins (no action in OFF).
REQ-024 stop during UP_WR/UP_WAIT: latched; the in-flight write completes, then next cycle enters DN_WR d0 (full power-down), no further up steps.
REQ-025 start during DN_*: ignored, not latched.
REQ-026 Host path: host_ready=1 in OFF and ON, 0 otherwise.
REQ-027 When host_ready=1, host_valid/host_data SHALL appear on valid_bus/master_data one cycle later, unchanged, except in ON where host_valid bits 7 and 8 are masked to 0.
REQ-028 host_reject SHALL pulse one cycle after a cycle with host_valid!=0 and host_ready=0, or in ON with host_valid[7] or host_valid[8] set.
REQ-029 Sequencer writes always take priority; host data is never queued (dropped, not delayed).
REQ-030 busy=1 in UP_*/DN_*; power_good=1 only in ON; both registered, consistent with state.

Reset
REQ-031 n_rst=0 sampled at a clk edge: state OFF, step 0, counter 0, pending stop cleared, all outputs 0 next cycle.
REQ-032 Reset mid-sequence SHALL abort with no further writes; recovery relies on register block's own reset values (rails off).
REQ-033 First cycle after reset release: host_ready=1, all else 0.

Verification (DELAY=4)
REQ-034 start in OFF -> writes reg9/0x01, reg7/0x00, reg8/0x00, reg6/0x01, reg9/0x00 at cycles t+1, t+6, t+11, t+16, t+21; power_good=1 from t+26.
REQ-035 stop in ON -> writes reg9/0x01, reg6/0x00, reg8/0x01, reg7/0x01 at 5-cycle spacing; then OFF, host_ready=1, busy=0.
REQ-036 stop pulsed during UP_WAIT after s1 -> no s2; d0..d3 follow, first d0 one cycle after current wait ends.
REQ-037 host_valid=0x004, data=0xA5 in OFF -> valid_bus=0x004, master_data=0xA5 next cycle; same in UP_WAIT -> valid_bus=0, host_reject=1.
REQ-038 ON, host_valid=0x180 -> valid_bus=0, host_reject=1; host_valid=0x001, data=0x07 -> forwarded.
REQ-039 start and stop same cycle in OFF -> no writes, state OFF; n_rst low during UP_WAIT -> all outputs 0, no further writes.

Source files
------------

// File: rtl/power_seq_if.sv
// Host write port and register-block write bus grouped for the power sequencer.
// Pure wiring: no logic or state, so it adds no latency.
// No backpressure: host_ready is advisory; writes presented while it is low are dropped.
//
// Signals:
//   host_data   [7:0]  host write data
//   host_valid  [9:0]  host register select, one bit per register
//   host_ready         host writes are currently forwarded
//   host_reject        one-cycle pulse for a dropped host write
//   master_data [7:0]  write data toward the register block
//   valid_bus   [9:0]  write strobes toward the register block
interface power_seq_if;
    logic [7:0] host_data;
    logic [9:0] host_valid;
    logic       host_ready;
    logic       host_reject;
    logic [7:0] master_data;
    logic [9:0] valid_bus;

    // slave: the sequencer side
    modport slave (
        input  host_data, host_valid,
        output host_ready, host_reject, master_data, valid_bus
    );

    // master: the host / environment side
    modport master (
        output host_data, host_valid,
        input  host_ready, host_reject, master_data, valid_bus
    );
endinterface

// File: rtl/power_seq.sv
// Power rail sequencer: runs fixed power-up/down write sequences to a register block, forwards host writes when idle.
// Latency: one cycle from start/stop or host write to valid_bus; sequencer writes are DELAY+1 cycles apart.
// No backpressure: host writes arriving while busy (or to masked registers in ON) are dropped and flagged by host_reject.
//
// Ports:
//   clk, n_rst    clock and synchronous active-low reset
//   start, stop   one-cycle power-up / power-down requests
//   bus           host port and register write bus (power_seq_if.slave)
//   busy          a sequence is running
//   power_good    rails are up (state ON)
module power_seq #(
    parameter int unsigned DELAY = 1000
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          stop,
    power_seq_if.slave    bus,
    output logic          busy,
    output logic          power_good
);

    typedef enum logic [2:0] {OFF, UP_WR, UP_WAIT, ON, DN_WR, DN_WAIT} state_t;

    localparam logic [15:0] DELAY_C  = 16'(DELAY);
    localparam logic [2:0]  UP_LAST  = 3'd4;
    localparam logic [2:0]  DN_LAST  = 3'd3;
    // Rail-off registers the host may not touch while powered up
    localparam logic [9:0]  ON_MASK  = 10'h180;

    state_t      state;
    logic [2:0]  step;
    logic [15:0] cnt;
    logic        stop_pend;

    // Sequence table: {register index, data} for each step
    function automatic logic [11:0] seq_word(input logic dn, input logic [2:0] s);
        logic [11:0] w;
        w = 12'h000;
        case ({dn, s})
            4'b0_000: w = {4'd9, 8'h01};
            4'b0_001: w = {4'd7, 8'h00};
            4'b0_010: w = {4'd8, 8'h00};
            4'b0_011: w = {4'd6, 8'h01};
            4'b0_100: w = {4'd9, 8'h00};
            4'b1_000: w = {4'd9, 8'h01};
            4'b1_001: w = {4'd6, 8'h00};
            4'b1_010: w = {4'd8, 8'h01};
            4'b1_011: w = {4'd7, 8'h01};
            default:  w = 12'h000;
        endcase
        return w;
    endfunction

    function automatic logic [9:0] strobe_of(input logic [11:0] w);
        return 10'b1 << w[11:8];
    endfunction

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= OFF;
            step            <= 3'd0;
            cnt             <= 16'd0;
            stop_pend       <= 1'b0;
            bus.valid_bus   <= '0;
            bus.master_data <= '0;
            bus.host_ready  <= 1'b0;
            bus.host_reject <= 1'b0;
            busy            <= 1'b0;
            power_good      <= 1'b0;
        end else begin
            // Strobes are single-cycle; only the branches below raise them
            bus.valid_bus   <= '0;
            bus.master_data <= '0;
            bus.host_reject <= 1'b0;
            // Defaults track the current state; transitions override them
            bus.host_ready  <= (state == OFF) || (state == ON);
            busy            <= (state != OFF) && (state != ON);
            power_good      <= (state == ON);

            case (state)
                OFF: begin
                    if (start && !stop) begin
                        state           <= UP_WR;
                        step            <= 3'd0;
                        bus.valid_bus   <= strobe_of(seq_word(1'b0, 3'd0));
                        bus.master_data <= seq_word(1'b0, 3'd0)[7:0];
                        bus.host_ready  <= 1'b0;
                        busy            <= 1'b1;
                        // The sequencer owns the bus in this slot
                        bus.host_reject <= |bus.host_valid;
                    end else begin
                        bus.valid_bus   <= bus.host_valid;
                        bus.master_data <= bus.host_data;
                    end
                end

                UP_WR: begin
                    state           <= UP_WAIT;
                    cnt             <= DELAY_C;
                    stop_pend       <= stop_pend | stop;
                    bus.host_reject <= |bus.host_valid;
                end

                UP_WAIT: begin
                    cnt             <= cnt - 16'd1;
                    stop_pend       <= stop_pend | stop;
                    bus.host_reject <= |bus.host_valid;
                    if (cnt == 16'd1) begin
                        if (stop_pend || stop) begin
                            // Abandon the remaining up steps and power down fully
                            state           <= DN_WR;
                            step            <= 3'd0;
                            stop_pend       <= 1'b0;
                            bus.valid_bus   <= strobe_of(seq_word(1'b1, 3'd0));
                            bus.master_data <= seq_word(1'b1, 3'd0)[7:0];
                        end else if (step == UP_LAST) begin
                            state          <= ON;
                            busy           <= 1'b0;
                            power_good     <= 1'b1;
                            bus.host_ready <= 1'b1;
                        end else begin
                            state           <= UP_WR;
                            step            <= step + 3'd1;
                            bus.valid_bus   <= strobe_of(seq_word(1'b0, step + 3'd1));
                            bus.master_data <= seq_word(1'b0, step + 3'd1)[7:0];
                        end
                    end
                end

                ON: begin
                    if (stop) begin
                        state           <= DN_WR;
                        step            <= 3'd0;
                        bus.valid_bus   <= strobe_of(seq_word(1'b1, 3'd0));
                        bus.master_data <= seq_word(1'b1, 3'd0)[7:0];
                        bus.host_ready  <= 1'b0;
                        busy            <= 1'b1;
                        power_good      <= 1'b0;
                        bus.host_reject <= |bus.host_valid;
                    end else begin
                        // Unmasked bits still go through; masked bits are dropped and flagged
                        bus.valid_bus   <= bus.host_valid & ~ON_MASK;
                        bus.master_data <= bus.host_data;
                        bus.host_reject <= |(bus.host_valid & ON_MASK);
                    end
                end

                DN_WR: begin
                    state           <= DN_WAIT;
                    cnt             <= DELAY_C;
                    bus.host_reject <= |bus.host_valid;
                end

                DN_WAIT: begin
                    cnt             <= cnt - 16'd1;
                    bus.host_reject <= |bus.host_valid;
                    if (cnt == 16'd1) begin
                        if (step == DN_LAST) begin
                            state          <= OFF;
                            busy           <= 1'b0;
                            bus.host_ready <= 1'b1;
                        end else begin
                            state           <= DN_WR;
                            step            <= step + 3'd1;
                            bus.valid_bus   <= strobe_of(seq_word(1'b1, step + 3'd1));
                            bus.master_data <= seq_word(1'b1, step + 3'd1)[7:0];
                        end
                    end
                end

                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_power_seq.sv
// Bench for power_seq with DELAY=4: directed stimulus pushes expected writes and status into queues,
// a negedge monitor matches them against the DUT by cycle number.
module tb_power_seq;

    logic clk = 1'b0;
    logic n_rst;
    logic start;
    logic stop;
    logic busy;
    logic power_good;
    logic done;
    int   cyc = 0;

    power_seq_if bus ();

    power_seq #(.DELAY(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .stop       (stop),
        .bus        (bus),
        .busy       (busy),
        .power_good (power_good)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] vb;
        logic [7:0] dat;
        logic       rej;
    } wr_t;

    typedef struct {
        int   cyc;
        logic rdy;
        logic bsy;
        logic pg;
    } st_t;

    wr_t exp_q[$];
    st_t st_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_wr(input int c, input logic [9:0] vb, input logic [7:0] d, input logic rej);
        wr_t e;
        e.cyc = c; e.vb = vb; e.dat = d; e.rej = rej;
        exp_q.push_back(e);
    endtask

    task automatic exp_st(input int c, input logic rdy, input logic bsy, input logic pg);
        st_t e;
        e.cyc = c; e.rdy = rdy; e.bsy = bsy; e.pg = pg;
        st_q.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        int  hit;
        logic present;
        hit = -1;
        present = (bus.valid_bus != 10'd0) || bus.host_reject;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_write cyc=%0d: not seen, want valid_bus=%h data=%h reject=%b",
                         exp_q[i].cyc, exp_q[i].vb, exp_q[i].dat, exp_q[i].rej);
                exp_q.delete(i);
            end
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].cyc == cyc && hit < 0) hit = i;
        if (hit >= 0) begin
            n_cmp++;
            if (bus.valid_bus !== exp_q[hit].vb || bus.host_reject !== exp_q[hit].rej ||
                (exp_q[hit].vb != 10'd0 && bus.master_data !== exp_q[hit].dat)) begin
                n_bad++;
                $display("FAIL write@%0d: got valid_bus=%h data=%h reject=%b, want valid_bus=%h data=%h reject=%b",
                         cyc, bus.valid_bus, bus.master_data, bus.host_reject,
                         exp_q[hit].vb, exp_q[hit].dat, exp_q[hit].rej);
            end
            exp_q.delete(hit);
        end else if (present) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write@%0d: got valid_bus=%h data=%h reject=%b, want no activity",
                     cyc, bus.valid_bus, bus.master_data, bus.host_reject);
        end

        for (int i = st_q.size() - 1; i >= 0; i--) begin
            if (st_q[i].cyc <= cyc) begin
                n_cmp++;
                if (st_q[i].cyc != cyc || bus.host_ready !== st_q[i].rdy ||
                    busy !== st_q[i].bsy || power_good !== st_q[i].pg) begin
                    n_bad++;
                    $display("FAIL status@%0d: got ready/busy/pg=%b%b%b, want %b%b%b",
                             st_q[i].cyc, bus.host_ready, busy, power_good,
                             st_q[i].rdy, st_q[i].bsy, st_q[i].pg);
                end
                st_q.delete(i);
            end
        end

        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0 || st_q.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: got %0d writes / %0d status pending, want 0 / 0",
                         exp_q.size(), st_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        n_rst = 1'b0; start = 1'b0; stop = 1'b0; done = 1'b0;
        bus.host_valid = '0; bus.host_data = '0;

        // Reset: everything low, then only host_ready after release
        tick(); tick();
        exp_st(3, 1'b0, 1'b0, 1'b0);
        exp_st(4, 1'b1, 1'b0, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();

        // Host forwarding in OFF, including multi-hot with bits 7/8
        t = cyc;
        bus.host_valid = 10'h004; bus.host_data = 8'hA5;
        exp_wr(t + 1, 10'h004, 8'hA5, 1'b0);
        tick();
        bus.host_valid = 10'h3C3; bus.host_data = 8'h5A;
        exp_wr(t + 2, 10'h3C3, 8'h5A, 1'b0);
        tick();
        bus.host_valid = '0; bus.host_data = '0;
        tick();

        // Power-up
        t = cyc;
        start = 1'b1;
        exp_wr(t + 1,  10'h200, 8'h01, 1'b0);
        exp_wr(t + 6,  10'h080, 8'h00, 1'b0);
        exp_wr(t + 11, 10'h100, 8'h00, 1'b0);
        exp_wr(t + 16, 10'h040, 8'h01, 1'b0);
        exp_wr(t + 21, 10'h200, 8'h00, 1'b0);
        exp_wr(t + 3,  10'h000, 8'h00, 1'b1);
        exp_st(t + 1,  1'b0, 1'b1, 1'b0);
        exp_st(t + 25, 1'b0, 1'b1, 1'b0);
        exp_st(t + 26, 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        tick();
        bus.host_valid = 10'h004; bus.host_data = 8'hA5;   // dropped while sequencing
        tick();
        bus.host_valid = '0; bus.host_data = '0;
        start = 1'b1;                                      // ignored while sequencing
        tick();
        start = 1'b0;
        to_cyc(t + 27);

        // ON: masked registers rejected, others forwarded
        t = cyc;
        bus.host_valid = 10'h180; bus.host_data = 8'h33;
        exp_wr(t + 1, 10'h000, 8'h00, 1'b1);
        tick();
        bus.host_valid = 10'h001; bus.host_data = 8'h07;
        exp_wr(t + 2, 10'h001, 8'h07, 1'b0);
        tick();
        bus.host_valid = 10'h081; bus.host_data = 8'h0F;
        exp_wr(t + 3, 10'h001, 8'h0F, 1'b1);
        tick();
        bus.host_valid = '0; bus.host_data = '0;
        start = 1'b1;                                      // ignored in ON
        tick();
        start = 1'b0;
        exp_st(cyc + 2, 1'b1, 1'b0, 1'b1);
        tick(); tick(); tick();

        // Power-down; start in the same cycle loses to stop
        t = cyc;
        stop = 1'b1; start = 1'b1;
        exp_wr(t + 1,  10'h200, 8'h01, 1'b0);
        exp_wr(t + 6,  10'h040, 8'h00, 1'b0);
        exp_wr(t + 11, 10'h100, 8'h01, 1'b0);
        exp_wr(t + 16, 10'h080, 8'h01, 1'b0);
        exp_st(t + 1,  1'b0, 1'b1, 1'b0);
        exp_st(t + 20, 1'b0, 1'b1, 1'b0);
        exp_st(t + 21, 1'b1, 1'b0, 1'b0);
        tick();
        stop = 1'b0; start = 1'b0;
        tick(); tick();
        start = 1'b1;                                      // not latched during power-down
        tick();
        start = 1'b0;
        to_cyc(t + 23);

        // start+stop together in OFF, then lone stop in OFF: nothing happens
        t = cyc;
        start = 1'b1; stop = 1'b1;
        exp_st(t + 1, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        exp_st(t + 3, 1'b1, 1'b0, 1'b0);
        tick();
        stop = 1'b0;
        to_cyc(t + 5);

        // Stop during the wait after s1: s2 never issued, full power-down follows
        t = cyc;
        start = 1'b1;
        exp_wr(t + 1,  10'h200, 8'h01, 1'b0);
        exp_wr(t + 6,  10'h080, 8'h00, 1'b0);
        exp_wr(t + 11, 10'h200, 8'h01, 1'b0);
        exp_wr(t + 16, 10'h040, 8'h00, 1'b0);
        exp_wr(t + 21, 10'h100, 8'h01, 1'b0);
        exp_wr(t + 26, 10'h080, 8'h01, 1'b0);
        exp_st(t + 30, 1'b0, 1'b1, 1'b0);
        exp_st(t + 31, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        to_cyc(t + 8);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        to_cyc(t + 33);

        // Reset during UP_WAIT aborts the sequence
        t = cyc;
        start = 1'b1;
        exp_wr(t + 1, 10'h200, 8'h01, 1'b0);
        tick();
        start = 1'b0;
        to_cyc(t + 3);
        n_rst = 1'b0;
        exp_st(t + 4, 1'b0, 1'b0, 1'b0);
        exp_st(t + 5, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        n_rst = 1'b1;
        exp_st(t + 6,  1'b1, 1'b0, 1'b0);
        exp_st(t + 30, 1'b1, 1'b0, 1'b0);
        to_cyc(t + 40);

        done = 1'b1;
        repeat (5) tick();
    end

endmodule
